// File: rtl/vec_lane_sequencer.sv
// Lane sequencer: streams 16-bit lanes of a vector op through one shared pipelined FP unit.
// Optional macro VDOT_EN compiles in the VDOT serial reduction (REDUCE state, accumulator).
module vec_lane_sequencer #(
   parameter int LANES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            opcode,
   input  logic [LANES*16-1:0]   op_1,
   input  logic [LANES*16-1:0]   op_2,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [LANES*16-1:0]   result,
   output logic                  fu_valid,
   output logic                  fu_mul,
   output logic [15:0]           fu_a,
   output logic [15:0]           fu_b,
   input  logic                  fu_rvalid,
   input  logic [15:0]           fu_rdata
);

   localparam int CW = $clog2(LANES) + 1;
   localparam int VW = LANES * 16;
   localparam logic [3:0] OP_VADD = 4'b0000;
   localparam logic [3:0] OP_SMUL = 4'b0010;
`ifdef VDOT_EN
   localparam logic [3:0] OP_VDOT = 4'b0001;
`endif
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(LANES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_DRAIN  = 3'd2,
`ifdef VDOT_EN
      S_REDUCE = 3'd3,
`endif
      S_FIN    = 3'd4
   } state_t;

   function automatic logic [15:0] lane_get(input logic [VW-1:0] v, input logic [CW-1:0] idx);
      lane_get = 16'h0000;
      for (int i = 0; i < LANES; i++) begin
         lane_get = (idx == CW'(i)) ? v[i*16 +: 16] : lane_get;
      end
   endfunction

   function automatic logic [VW-1:0] lane_set(input logic [VW-1:0] v, input logic [CW-1:0] idx,
                                             input logic [15:0] d);
      lane_set = v;
      for (int i = 0; i < LANES; i++) begin
         lane_set[i*16 +: 16] = (idx == CW'(i)) ? d : lane_set[i*16 +: 16];
      end
   endfunction

   function automatic logic op_supported(input logic [3:0] op);
`ifdef VDOT_EN
      op_supported = (op == OP_VADD) || (op == OP_SMUL) || (op == OP_VDOT);
`else
      op_supported = (op == OP_VADD) || (op == OP_SMUL);
`endif
   endfunction

   state_t         state_r, state_nxt_s;
   logic [3:0]     opc_r, opc_nxt_s;
   logic [VW-1:0]  a_r, a_nxt_s, b_r, b_nxt_s;
   logic [CW-1:0]  icnt_r, icnt_nxt_s, rcnt_r, rcnt_nxt_s;
   logic [VW-1:0]  result_r, result_nxt_s;
   logic           busy_r, busy_nxt_s, done_r, done_nxt_s, err_r, err_nxt_s;
   logic           fu_valid_r, fu_valid_nxt_s, fu_mul_r, fu_mul_nxt_s;
   logic [15:0]    fu_a_r, fu_a_nxt_s, fu_b_r, fu_b_nxt_s;
`ifdef VDOT_EN
   logic [CW-1:0]  kcnt_r, kcnt_nxt_s;
   logic [15:0]    acc_r, acc_nxt_s;
   logic           pend_r, pend_nxt_s;
`endif

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_nxt_s    = state_r;
      opc_nxt_s      = opc_r;
      a_nxt_s        = a_r;
      b_nxt_s        = b_r;
      icnt_nxt_s     = icnt_r;
      rcnt_nxt_s     = rcnt_r;
      result_nxt_s   = result_r;
      done_nxt_s     = 1'b0;
      err_nxt_s      = 1'b0;
      fu_valid_nxt_s = 1'b0;
      fu_mul_nxt_s   = fu_mul_r;
      fu_a_nxt_s     = fu_a_r;
      fu_b_nxt_s     = fu_b_r;
`ifdef VDOT_EN
      kcnt_nxt_s     = kcnt_r;
      acc_nxt_s      = acc_r;
      pend_nxt_s     = pend_r;
`endif

      // In-order response capture overlaps issue; responses seen elsewhere are dropped.
      if ((state_r == S_ISSUE || state_r == S_DRAIN) && fu_rvalid && (rcnt_r != CNT_FULL)) begin
         result_nxt_s = lane_set(result_r, rcnt_r, fu_rdata);
         rcnt_nxt_s   = rcnt_r + CNT_ONE;
      end else begin
         rcnt_nxt_s   = rcnt_r;
      end

      case (state_r)
         S_IDLE: begin
            if (start) begin
               opc_nxt_s  = opcode;
               a_nxt_s    = op_1;
               b_nxt_s    = op_2;
               icnt_nxt_s = CNT_ZERO;
               rcnt_nxt_s = CNT_ZERO;
               if (op_supported(opcode)) begin
                  // Lane 0 issues straight from the inputs so there is no bubble after accept.
                  result_nxt_s   = {VW{1'b0}};
                  state_nxt_s    = S_ISSUE;
                  fu_valid_nxt_s = 1'b1;
                  fu_mul_nxt_s   = (opcode != OP_VADD);
                  fu_a_nxt_s     = op_1[15:0];
                  fu_b_nxt_s     = op_2[15:0];
                  icnt_nxt_s     = CNT_ONE;
               end else begin
                  state_nxt_s = S_FIN;
                  done_nxt_s  = 1'b1;
                  err_nxt_s   = 1'b1;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            fu_valid_nxt_s = 1'b1;
            fu_mul_nxt_s   = (opc_r != OP_VADD);
            fu_a_nxt_s     = (opc_r == OP_SMUL) ? lane_get(a_r, CNT_ZERO) : lane_get(a_r, icnt_r);
            fu_b_nxt_s     = lane_get(b_r, icnt_r);
            icnt_nxt_s     = icnt_r + CNT_ONE;
            if (icnt_r == CNT_LAST) begin
               state_nxt_s = S_DRAIN;
            end else begin
               state_nxt_s = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (rcnt_nxt_s == CNT_FULL) begin
`ifdef VDOT_EN
               if (opc_r == OP_VDOT) begin
                  state_nxt_s = S_REDUCE;
                  acc_nxt_s   = lane_get(result_nxt_s, CNT_ZERO);
                  kcnt_nxt_s  = CNT_ONE;
                  pend_nxt_s  = 1'b0;
               end else begin
                  state_nxt_s = S_FIN;
                  done_nxt_s  = 1'b1;
               end
`else
               state_nxt_s = S_FIN;
               done_nxt_s  = 1'b1;
`endif
            end else begin
               state_nxt_s = S_DRAIN;
            end
         end
`ifdef VDOT_EN
         S_REDUCE: begin
            if (!pend_r) begin
               fu_valid_nxt_s = 1'b1;
               fu_mul_nxt_s   = 1'b0;
               fu_a_nxt_s     = acc_r;
               fu_b_nxt_s     = lane_get(result_r, kcnt_r);
               pend_nxt_s     = 1'b1;
            end else if (fu_rvalid) begin
               // Each partial sum feeds the next add the same edge it arrives.
               if (kcnt_r == CNT_LAST) begin
                  result_nxt_s = {{(VW-16){1'b0}}, fu_rdata};
                  state_nxt_s  = S_FIN;
                  done_nxt_s   = 1'b1;
                  pend_nxt_s   = 1'b0;
               end else begin
                  acc_nxt_s      = fu_rdata;
                  kcnt_nxt_s     = kcnt_r + CNT_ONE;
                  fu_valid_nxt_s = 1'b1;
                  fu_mul_nxt_s   = 1'b0;
                  fu_a_nxt_s     = fu_rdata;
                  fu_b_nxt_s     = lane_get(result_r, kcnt_r + CNT_ONE);
               end
            end else begin
               state_nxt_s = S_REDUCE;
            end
         end
`endif
         S_FIN: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase

      busy_nxt_s = (state_nxt_s != S_IDLE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         opc_r      <= 4'b0000;
         a_r        <= {VW{1'b0}};
         b_r        <= {VW{1'b0}};
         icnt_r     <= CNT_ZERO;
         rcnt_r     <= CNT_ZERO;
         result_r   <= {VW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         fu_valid_r <= 1'b0;
         fu_mul_r   <= 1'b0;
         fu_a_r     <= 16'h0000;
         fu_b_r     <= 16'h0000;
`ifdef VDOT_EN
         kcnt_r     <= CNT_ZERO;
         acc_r      <= 16'h0000;
         pend_r     <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt_s;
         opc_r      <= opc_nxt_s;
         a_r        <= a_nxt_s;
         b_r        <= b_nxt_s;
         icnt_r     <= icnt_nxt_s;
         rcnt_r     <= rcnt_nxt_s;
         result_r   <= result_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         err_r      <= err_nxt_s;
         fu_valid_r <= fu_valid_nxt_s;
         fu_mul_r   <= fu_mul_nxt_s;
         fu_a_r     <= fu_a_nxt_s;
         fu_b_r     <= fu_b_nxt_s;
`ifdef VDOT_EN
         kcnt_r     <= kcnt_nxt_s;
         acc_r      <= acc_nxt_s;
         pend_r     <= pend_nxt_s;
`endif
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;
   assign result   = result_r;
   assign fu_valid = fu_valid_r;
   assign fu_mul   = fu_mul_r;
   assign fu_a     = fu_a_r;
   assign fu_b     = fu_b_r;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Self-checking bench for vec_lane_sequencer: a latency-L half-precision FP unit model plus an
// operation-level reference model (results, issue operands, done cycle); honours VDOT_EN.
module tb_vec_lane_sequencer;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    opcode = 4'h0;
   logic [255:0]  op_1 = '0;
   logic [255:0]  op_2 = '0;
   logic          busy, done, err, fu_valid, fu_mul;
   logic [255:0]  result;
   logic [15:0]   fu_a, fu_b;
   logic          fu_rvalid = 1'b0;
   logic [15:0]   fu_rdata = 16'h0000;

   int n_cmp = 0;
   int n_bad = 0;
   int fu_lat = 1;
   int ncyc = 0;
   int          due_q[$];
   logic [15:0] dat_q[$];
   logic [15:0] log_a[$], log_b[$];
   logic        log_m[$];
   logic [15:0] ex_a[$], ex_b[$];
   logic        ex_m[$];
   logic [255:0] exp_res = '0;

   always #5 clk = ~clk;

   vec_lane_sequencer #(.LANES(16)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op_1(op_1), .op_2(op_2),
      .busy(busy), .done(done), .err(err), .result(result),
      .fu_valid(fu_valid), .fu_mul(fu_mul), .fu_a(fu_a), .fu_b(fu_b),
      .fu_rvalid(fu_rvalid), .fu_rdata(fu_rdata)
   );

   function automatic real f2r(input logic [15:0] h);
      real v;
      int  e;
      e = int'(h[14:10]);
      if (e == 0) begin
         v = real'(int'(h[9:0])) / 16777216.0;
      end else begin
         v = 1.0 + real'(int'(h[9:0])) / 1024.0;
         for (int i = 0; i < e - 15; i++) v = v * 2.0;
         for (int i = 0; i < 15 - e; i++) v = v / 2.0;
      end
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2f(input real x);
      logic s;
      real  ax;
      int   e, m;
      if (x == 0.0) return 16'h0000;
      s  = (x < 0.0);
      ax = s ? -x : x;
      if (ax < 6.103515625e-05) begin
         m = $rtoi($floor(ax * 16777216.0 + 0.5));
         return {s, 15'(m)};
      end
      e = 0;
      while (ax >= 2.0) begin ax = ax / 2.0; e++; end
      while (ax < 1.0) begin ax = ax * 2.0; e--; end
      m = $rtoi($floor((ax - 1.0) * 1024.0 + 0.5));
      if (m == 1024) begin m = 0; e++; end
      if (e > 15) return {s, 15'h7C00};
      return {s, 5'(e + 15), 10'(m)};
   endfunction

   function automatic logic [15:0] fpadd(input logic [15:0] a, input logic [15:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   function automatic logic [15:0] fpmul(input logic [15:0] a, input logic [15:0] b);
      return r2f(f2r(a) * f2r(b));
   endfunction

   function automatic logic [255:0] rvec();
      logic [255:0] v;
      for (int i = 0; i < 16; i++)
         v[16*i +: 16] = {1'(($urandom_range(0, 1))), 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))};
      return v;
   endfunction

   // Pipelined FP unit model: fixed latency, in-order responses, logs every issue.
   always @(negedge clk) begin
      fu_rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == ncyc) begin
         fu_rvalid = 1'b1;
         fu_rdata  = dat_q.pop_front();
         void'(due_q.pop_front());
      end
      if (fu_valid === 1'b1) begin
         due_q.push_back(ncyc + fu_lat);
         dat_q.push_back(fu_mul ? fpmul(fu_a, fu_b) : fpadd(fu_a, fu_b));
         log_a.push_back(fu_a);
         log_b.push_back(fu_b);
         log_m.push_back(fu_mul);
      end
      ncyc++;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Operation-level reference: expected result, err, done cycle and issue list.
   task automatic ref_op(input logic [3:0] opc, input logic [255:0] a, input logic [255:0] b,
                         input int lat, output logic [255:0] res, output logic e,
                         output int k, output int n);
      logic [15:0] p[16];
      logic [15:0] acc;
      bit sup;
      sup = (opc == 4'h0) || (opc == 4'h2);
`ifdef VDOT_EN
      if (opc == 4'h1) sup = 1'b1;
`endif
      ex_a.delete(); ex_b.delete(); ex_m.delete();
      res = exp_res;
      e   = 1'b0;
      if (!sup) begin
         e = 1'b1; k = 1; n = 0;
      end else if (opc != 4'h1) begin
         for (int i = 0; i < 16; i++) begin
            ex_a.push_back(opc == 4'h2 ? a[15:0] : a[16*i +: 16]);
            ex_b.push_back(b[16*i +: 16]);
            ex_m.push_back(opc == 4'h2);
            res[16*i +: 16] = (opc == 4'h2) ? fpmul(a[15:0], b[16*i +: 16])
                                            : fpadd(a[16*i +: 16], b[16*i +: 16]);
         end
         k = 17 + lat; n = 16;
      end else begin
         for (int i = 0; i < 16; i++) begin
            p[i] = fpmul(a[16*i +: 16], b[16*i +: 16]);
            ex_a.push_back(a[16*i +: 16]); ex_b.push_back(b[16*i +: 16]); ex_m.push_back(1'b1);
         end
         acc = p[0];
         for (int j = 1; j < 16; j++) begin
            ex_a.push_back(acc); ex_b.push_back(p[j]); ex_m.push_back(1'b0);
            acc = fpadd(acc, p[j]);
         end
         res = {240'h0, acc};
         k = 17 + lat + 15 * (lat + 1) + 1; n = 31;
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] opc, input logic [255:0] a,
                         input logic [255:0] b, input int lat);
      logic [255:0] er;
      logic ee;
      int ek, en, k, nval, first, bad;
      ref_op(opc, a, b, lat, er, ee, ek, en);
      log_a.delete(); log_b.delete(); log_m.delete();
      fu_lat = lat;
      @(negedge clk);
      opcode = opc; op_1 = a; op_2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; k = 1; nval = 0; first = 0;
      chk({tag, "_busy_t1"}, busy, 1);
      while (done !== 1'b1 && k < 4000) begin
         if (fu_valid === 1'b1) begin
            nval++;
            if (first == 0) first = k;
         end
         if (k == 5) begin start = 1'b1; opcode = 4'hF; end
         else start = 1'b0;
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, k, ek);
      chk({tag, "_err"}, err, ee);
      chk({tag, "_busy_at_done"}, busy, 1);
      chk({tag, "_result"}, result, er);
      exp_res = er;
      chk({tag, "_issue_count"}, nval, en);
      if (en > 0) chk({tag, "_first_issue"}, first, 1);
      chk({tag, "_log_size"}, log_a.size(), en);
      bad = 0;
      for (int i = 0; i < en && i < log_a.size(); i++)
         if (log_a[i] !== ex_a[i] || log_b[i] !== ex_b[i] || log_m[i] !== ex_m[i]) bad++;
      chk({tag, "_operands_bad"}, bad, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle_after"}, busy, 0);
   endtask

   initial begin
      logic [255:0] a, b, saved;
      logic [3:0]   oc;
      int           r;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_fu_valid", fu_valid, 0);
      chk("rst_fu_mul", fu_mul, 0);
      chk("rst_fu_a", fu_a, 0);
      chk("rst_fu_b", fu_b, 0);
      chk("rst_result", result, 0);
      rst = 1'b0;

      a = {16{16'h3C00}};
      run_op("vadd_ones", 4'h0, a, a, 3);
      chk("vadd_ones_const", result, {16{16'h4000}});

      a = 256'h4000;
      for (int i = 0; i < 16; i++) b[16*i +: 16] = 16'(i);
      run_op("smul_ramp", 4'h2, a, b, 2);
      saved = result;
      chk("smul_lane3_const", saved[63:48], 16'h0006);

      a = {16{16'h3C00}};
      run_op("vdot_ones", 4'h1, a, a, 2);
`ifdef VDOT_EN
      chk("vdot_ones_const", result, {240'h0, 16'h4C00});
`else
      chk("vdot_disabled_unchanged", result, saved);
`endif

      saved = result;
      run_op("bad_opcode", 4'hF, rvec(), rvec(), 1);
      chk("bad_opcode_unchanged", result, saved);

      for (int t = 0; t < 8; t++) begin
         r = $urandom_range(0, 4);
         oc = (r < 3) ? 4'(r) : 4'($urandom_range(3, 15));
         run_op("rand_op", oc, rvec(), rvec(), $urandom_range(1, 5));
      end

      fu_lat = 3;
      @(negedge clk);
      opcode = 4'h0; op_1 = rvec(); op_2 = rvec(); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_fu_valid", fu_valid, 0);
      chk("midrst_result", result, 0);
      exp_res = '0;
      repeat (12) @(negedge clk);
      chk("midrst_stale_ignored", result, 0);
      chk("midrst_still_idle", busy, 0);
      run_op("vadd_after_rst", 4'h0, rvec(), rvec(), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vec_lane_sequencer.md
# vec_lane_sequencer

Sequences 256-bit vector instructions (16 lanes × 16-bit half-precision) through one shared, pipelined scalar FP unit, one lane per cycle. It sits between decode and the scalar FP unit. It latches operands on `start`, issues lane operations, collects in-order responses into a 256-bit result buffer, and pulses `done`. VDOT adds a serial reduction phase on the same unit.

## Interface
- `LANES`, default 16: number of lanes; lane i is bits [16i+15:16i].
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `opcode` in 4: 0000 VADD, 0001 VDOT, 0010 SMUL; any other value is unsupported.
- `op_1` in 256: vector A; SMUL uses only lane 0 as the scalar.
- `op_2` in 256: vector B.
- `busy` out 1: high from the cycle after acceptance through the `done` cycle.
- `done` out 1: one-cycle pulse when `result` is valid.
- `err` out 1: valid with `done`; high for an unsupported opcode.
- `result` out 256: result buffer; holds its value until the next accepted op.
- `fu_valid` out 1: issue strobe to the FP unit.
- `fu_mul` out 1: 0 = add, 1 = multiply.
- `fu_a`, `fu_b` out 16: FP unit operands.
- `fu_rvalid` in 1: response strobe; responses return in issue order, fixed latency ≥1.
- `fu_rdata` in 16: response data.

## Operation
- States: IDLE, ISSUE, DRAIN, REDUCE, FIN.
- IDLE:
  - `start`=1 latches `opcode`, `op_1`, `op_2`, clears issue/response counters.
  - Supported opcode → ISSUE, and `result` is cleared.
  - Unsupported opcode → FIN with `err`=1, `result` unchanged.
- ISSUE: lane `icnt` is issued each cycle (`fu_valid`=1), `icnt` 0..LANES-1. After the last lane → DRAIN.
  - VADD: a=A[i], b=B[i], add.
  - SMUL: a=A[0], b=B[i], mul.
  - VDOT: a=A[i], b=B[i], mul.
- Response capture (ISSUE and DRAIN): each `fu_rvalid` writes `fu_rdata` into lane `rcnt` of the buffer, then increments `rcnt`. Capture can overlap issue.
- DRAIN: waits until `rcnt`=LANES. Then VADD/SMUL → FIN; VDOT → REDUCE.
- REDUCE (VDOT only), serial and dependent:
  - acc = lane0.
  - For k=1..LANES-1: issue add(acc, lane k), wait for the response, acc = response. Only one add is outstanding at a time.
  - At the end: lane 0 = acc, lanes 1..15 = 0 → FIN.
- FIN: `done`=1 for one cycle, `busy`=1 → IDLE.
- A `start` while `busy`=1 is ignored; there is no queueing.
- An `fu_rvalid` in IDLE or FIN is ignored.
- Counters are log2(LANES)+1 bits wide, so there is no wrap.
- No FP arithmetic happens in this block; values pass through bit-exact.

## Timing
- Reset: all outputs 0 (`busy`, `done`, `err`, `fu_valid`, `fu_mul`, `fu_a`, `fu_b`, `result`); state = IDLE; counters = 0.
- Reset mid-op aborts immediately. In-flight responses arriving after reset are ignored.
- `start` is sampled at edge T0. `fu_valid` is high on cycles T1..T16, one lane per cycle with no bubbles.
- Let L be the FP unit latency. The last response arrives at T16+L. `done` is at T17+L for VADD/SMUL.
- VDOT: `done` at T17+L + 15·(L+1) + 1.
- Unsupported opcode: `done`=`err`=1 at T1.
- After `done`, a new `start` is accepted in the next cycle, since the block is in IDLE.

## Configuration
- `VDOT_EN` defined: VDOT supported, and the REDUCE state and accumulator are compiled in.
- `VDOT_EN` undefined: opcode 0001 is unsupported (`err`=1, `done` at T1), and no REDUCE logic exists.

## Test plan
- Reset check: assert `rst` for 2 cycles → all outputs 0, `busy`=0.
- VADD: all lanes A=16'h3C00, B=16'h3C00, model L=3 adds → `fu_valid` for 16 consecutive cycles, `done` at T20, every lane 16'h4000.
- SMUL: A lane0=16'h4000, B lane i=i → issues carry a=16'h4000, `fu_mul`=1; result lane i = model product.
- VDOT (`VDOT_EN`): A=B=16'h3C00 in all lanes, L=2 → result lane0=16'h4C00 (16.0), other lanes 0, `done` at T19+45+1.
- Opcode 4'b1111 → `done`=`err`=1 at T1, `result` unchanged; also `start` pulsed while busy → ignored.
- Reset at T8 of VADD, then a new VADD → stale responses ignored, second result correct.
